mmu_weight_loader: RTL and testbench
====================================

Name: mmu_weight_loader

Overview:
- Upstream stage of the 2x2 systolic MMU.
- Accepts one 2x2 weight tile from the weight FIFO over a valid/ready stream and buffers it.
- Once the MMU is not computing, replays the tile into the array's column psum inputs with column-1 skew, driving the pass and per-column capture enables.
- Signals completion so the compute sequencer can start streaming activations.

Parameters:
- DATA_W, 8, weight width in bits; matches MMU col inputs.
- CAP_LAT, 1, cycles from the top-row weight being presented on a column to that column's capture strobe (1..3).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- in_valid  input  1  weight beat valid from the weight FIFO.
- in_ready  output  1  loader can accept a beat.
- in_data  input  2*DATA_W  beat: [DATA_W-1:0] = column-0 weight, [2*DATA_W-1:DATA_W] = column-1 weight.
- mmu_busy  input  1  compute in progress; a load must not start while 1.
- col0_out  output  DATA_W  to MMU col0_in.
- col1_out  output  DATA_W  to MMU col1_in.
- en_weight_pass  output  1  to MMU en_weight_pass.
- en_capture_col0  output  1  to MMU en_capture_col0.
- en_capture_col1  output  1  to MMU en_capture_col1.
- load_active  output  1  high for every LOAD cycle.
- weights_loaded  output  1  one-cycle pulse after the final capture.

Behaviour:
- All outputs are registered.
- Reset values: in_ready=0, col0_out=0, col1_out=0, all enables=0, load_active=0, weights_loaded=0. State goes to IDLE and the beat count to 0.
- in_ready rises in the first cycle after reset deasserts.
- Transfer occurs when in_valid && in_ready at a clock edge.
- Tile order: beat 0 = bottom row (W10 col0, W11 col1); beat 1 = top row (W00, W01). The beats are stored in a two-entry buffer.
- IDLE:
  - in_ready=1.
  - On the 1st transfer, store it and set count=1.
  - On the 2nd transfer, store it and go to ARMED.
  - in_ready drops in the cycle after the 2nd transfer; no beat is accepted outside IDLE.
- ARMED:
  - in_ready=0.
  - Wait while mmu_busy=1.
  - With mmu_busy=0 sampled at an edge, go to LOAD with k=0.
- LOAD: k counts 0..2+CAP_LAT; en_weight_pass=1 and load_active=1 throughout. Per-cycle outputs:
  - k=0: col0=W10, col1=0.
  - k=1: col0=W00, col1=W11.
  - k=2: col0=0, col1=W01.
  - k>=3: col0=0, col1=0.
  - en_capture_col0=1 only at k=1+CAP_LAT.
  - en_capture_col1=1 only at k=2+CAP_LAT.
  - After k=2+CAP_LAT, go to DONE.
  - mmu_busy is ignored once LOAD has started.
- DONE:
  - One cycle: weights_loaded=1; all enables 0; cols 0.
  - Then go to IDLE and clear count.
- LOAD length is 3+CAP_LAT cycles. First in_valid to weights_loaded latency with mmu_busy=0 and back-to-back beats: 2 accept cycles + 1 ARMED + 3+CAP_LAT LOAD + 1 DONE.
- in_valid held high while in_ready=0: no transfer and no buffer change.
- Beat arrives after a gap: the count holds; there is no timeout.
- reset asserted mid-LOAD:
  - All outputs clear immediately (asynchronous).
  - The buffered tile is discarded.
  - No capture strobe may appear after reset asserts.
- A capture strobe never occurs without en_weight_pass=1 in the same cycle.

Test Plan:
- Basic load, CAP_LAT=1, mmu_busy=0:
  - Stimulus: beats {W11=0x04,W10=0x03}, then {W01=0x02,W00=0x01}.
  - LOAD cycles col0/col1 = 03/00, 01/04, 00/02, 00/00.
  - cap0 at k=2, cap1 at k=3, pass high for 4 cycles.
  - weights_loaded pulses exactly once, the cycle after k=3.
- Busy stall:
  - Stimulus: hold mmu_busy=1 for 5 cycles after the tile is full.
  - LOAD begins the edge after mmu_busy falls; in_ready stays 0 throughout ARMED.
- Backpressure and gaps:
  - Stimulus: in_valid toggles 1,0,0,1; then a third beat is offered during ARMED.
  - Exactly two beats are accepted; the third is held off (in_ready=0) until after DONE.
- CAP_LAT=3:
  - cap0 at k=4, cap1 at k=5.
  - LOAD lasts 6 cycles, with cols 0 from k=3.
- Reset mid-LOAD:
  - Stimulus: reset=0 at k=1, released 2 cycles later.
  - All outputs are 0 within the reset window and no captures occur.
  - in_ready=1 after release, and a fresh tile loads correctly.
- Back-to-back tiles:
  - Stimulus: tile B beats are offered continuously.
  - B is accepted starting the cycle after the DONE of tile A.
  - B's sequence is correct with no carry-over of tile A data.

Source files
------------

// File: rtl/mmu_weight_loader.sv
// mmu_weight_loader
// Upstream stage of the 2x2 systolic MMU. Buffers one 2x2 weight tile from the
// weight FIFO, waits for the array to go idle, then replays the tile into the
// column psum inputs with column-1 skewed one cycle behind column 0, strobing
// the per-column capture enables, and finally pulses weights_loaded.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset
//   in_valid        weight beat valid from the weight FIFO
//   in_ready        loader can accept a beat (registered)
//   in_data         beat: [DATA_W-1:0] col-0 weight, [2*DATA_W-1:DATA_W] col-1 weight
//   mmu_busy        compute in progress; a load is held off while high
//   col0_out        weight driven into MMU column 0
//   col1_out        weight driven into MMU column 1
//   en_weight_pass  MMU weight pass-through enable
//   en_capture_col0 MMU column-0 capture strobe
//   en_capture_col1 MMU column-1 capture strobe
//   load_active     high for every LOAD cycle
//   weights_loaded  one-cycle pulse after the final capture
//
// Beat 0 of a tile is the bottom row (W10, W11), beat 1 the top row (W00, W01).
// All outputs are registered: the output logic evaluates the *next* state and
// step so that the registered outputs line up with the state they describe.

module mmu_weight_loader #(
  parameter int DATA_W  = 8,
  parameter int CAP_LAT = 1   // 1..3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_data,
  input  logic                mmu_busy,
  output logic [DATA_W-1:0]   col0_out,
  output logic [DATA_W-1:0]   col1_out,
  output logic                en_weight_pass,
  output logic                en_capture_col0,
  output logic                en_capture_col1,
  output logic                load_active,
  output logic                weights_loaded
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_LOAD, S_DONE} state_t;

  localparam int             K_W    = 3;
  localparam logic [K_W-1:0] K_CAP0 = K_W'(1 + CAP_LAT);
  localparam logic [K_W-1:0] K_LAST = K_W'(2 + CAP_LAT);  // also column-1 capture step

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic                count_q, count_d;   // beats already buffered in IDLE (0 or 1)
  logic [2*DATA_W-1:0] bot_q, top_q;       // bottom row (beat 0), top row (beat 1)

  logic                in_ready_d;
  logic [DATA_W-1:0]   col0_d, col1_d;
  logic                pass_d, cap0_d, cap1_d, loaded_d;

  // Handshake uses the registered in_ready so acceptance is only ever in IDLE.
  logic xfer;
  assign xfer = in_valid && in_ready;

  // State register, step counter, tile buffer and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // NOTE: the two-entry tile buffer is reset as well, so a tile interrupted by
  // reset can never leak into a later load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      k_q             <= '0;
      count_q         <= 1'b0;
      bot_q           <= '0;
      top_q           <= '0;
      in_ready        <= 1'b0;
      col0_out        <= '0;
      col1_out        <= '0;
      en_weight_pass  <= 1'b0;
      en_capture_col0 <= 1'b0;
      en_capture_col1 <= 1'b0;
      load_active     <= 1'b0;
      weights_loaded  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      count_q <= count_d;
      if (state_q == S_IDLE && xfer) begin
        if (!count_q) bot_q <= in_data;
        else          top_q <= in_data;
      end
      in_ready        <= in_ready_d;
      col0_out        <= col0_d;
      col1_out        <= col1_d;
      en_weight_pass  <= pass_d;
      en_capture_col0 <= cap0_d;
      en_capture_col1 <= cap1_d;
      load_active     <= pass_d;
      weights_loaded  <= loaded_d;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (count_q) state_d = S_ARMED;
          else         count_d = 1'b1;
        end
      end
      S_ARMED: begin
        if (!mmu_busy) begin
          state_d = S_LOAD;
          k_d     = '0;
        end
      end
      S_LOAD: begin
        // mmu_busy is deliberately not looked at once the replay has started.
        if (k_q == K_LAST) state_d = S_DONE;
        else               k_d     = k_q + K_W'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
        count_d = 1'b0;
        k_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        count_d = 1'b0;
        k_d     = '0;
      end
    endcase
  end

  // Output logic: values for the cycle that follows the coming edge.
  // Column 1 trails column 0 by one step (W10/W00 on col0 at k=0/1,
  // W11/W01 on col1 at k=1/2); captures are gated by LOAD, so they can
  // only coincide with en_weight_pass.
  always_comb begin
    in_ready_d = (state_d == S_IDLE);
    pass_d     = (state_d == S_LOAD);
    loaded_d   = (state_d == S_DONE);
    col0_d     = '0;
    col1_d     = '0;
    cap0_d     = 1'b0;
    cap1_d     = 1'b0;
    if (state_d == S_LOAD) begin
      case (k_d)
        K_W'(0): col0_d = bot_q[DATA_W-1:0];
        K_W'(1): begin
          col0_d = top_q[DATA_W-1:0];
          col1_d = bot_q[2*DATA_W-1:DATA_W];
        end
        K_W'(2): col1_d = top_q[2*DATA_W-1:DATA_W];
        default: ;
      endcase
      cap0_d = (k_d == K_CAP0);
      cap1_d = (k_d == K_LAST);
    end
  end

endmodule

// File: tb/tb_mmu_weight_loader.sv
// Testbench for mmu_weight_loader. Two instances: u_dut1 (CAP_LAT=1) carries
// the table-driven basic load and the multi-cycle corner cases; u_dut3
// (CAP_LAT=3) checks the longer capture latency. Output vectors are packed as
// {in_ready, col0, col1, pass, cap0, cap1, load_active, weights_loaded}.

module tb_mmu_weight_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // CAP_LAT = 1 instance
  logic        iv1, busy1;
  logic [15:0] id1;
  logic        rdy1, pass1, cap0_1, cap1_1, la1, wl1;
  logic [7:0]  c0_1, c1_1;

  // CAP_LAT = 3 instance
  logic        iv3, busy3;
  logic [15:0] id3;
  logic        rdy3, pass3, cap0_3, cap1_3, la3, wl3;
  logic [7:0]  c0_3, c1_3;

  mmu_weight_loader #(.DATA_W(8), .CAP_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(rdy1), .in_data(id1),
    .mmu_busy(busy1), .col0_out(c0_1), .col1_out(c1_1), .en_weight_pass(pass1),
    .en_capture_col0(cap0_1), .en_capture_col1(cap1_1), .load_active(la1),
    .weights_loaded(wl1)
  );

  mmu_weight_loader #(.DATA_W(8), .CAP_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(rdy3), .in_data(id3),
    .mmu_busy(busy3), .col0_out(c0_3), .col1_out(c1_3), .en_weight_pass(pass3),
    .en_capture_col0(cap0_3), .en_capture_col1(cap1_3), .load_active(la3),
    .weights_loaded(wl3)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        iv;
    logic [15:0] data;
    logic        busy;
    logic [21:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [21:0] pk(input logic ir, input logic [7:0] c0, input logic [7:0] c1,
                                     input logic p, input logic a, input logic b,
                                     input logic la, input logic wl);
    return {ir, c0, c1, p, a, b, la, wl};
  endfunction

  function automatic vec_t row(input logic iv, input logic [15:0] d, input logic busy,
                               input logic [21:0] exp, input string name);
    vec_t r;
    r.iv = iv; r.data = d; r.busy = busy; r.exp = exp; r.name = name;
    return r;
  endfunction

  function automatic logic [21:0] get_vec(input int which);
    if (which == 3) return {rdy3, c0_3, c1_3, pass3, cap0_3, cap1_3, la3, wl3};
    return {rdy1, c0_1, c1_1, pass1, cap0_1, cap1_1, la1, wl1};
  endfunction

  // Expected outputs for LOAD step k of a tile with the given capture latency.
  function automatic logic [21:0] exp_load(input int cl, input int k,
                                           input logic [7:0] w10, input logic [7:0] w11,
                                           input logic [7:0] w00, input logic [7:0] w01);
    logic [7:0] c0, c1;
    c0 = (k == 0) ? w10 : (k == 1) ? w00 : 8'h00;
    c1 = (k == 1) ? w11 : (k == 2) ? w01 : 8'h00;
    return pk(1'b0, c0, c1, 1'b1, (k == 1 + cl), (k == 2 + cl), 1'b1, 1'b0);
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic v, input logic [15:0] d);
    if (which == 3) begin iv3 = v; id3 = d; end
    else            begin iv1 = v; id1 = d; end
  endtask

  task automatic set_busy(input int which, input logic b);
    if (which == 3) busy3 = b;
    else            busy1 = b;
  endtask

  // Offer one beat and return just after the edge that accepted it.
  task automatic send_beat(input int which, input logic [15:0] d, input string tag);
    bit done = 0;
    drive(which, 1'b1, d);
    for (int i = 0; i < 40 && !done; i++) begin
      if (get_vec(which)[21]) done = 1;
      step();
    end
    drive(which, 1'b0, 16'h0000);
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: in_ready never rose, got 0 expected 1", tag);
    end
  endtask

  // Caller leaves the instance in ARMED with busy low; the next edge enters LOAD.
  task automatic expect_load(input int which, input string tag,
                             input logic [7:0] w10, input logic [7:0] w11,
                             input logic [7:0] w00, input logic [7:0] w01,
                             input logic busy_in_load);
    int cl = (which == 3) ? 3 : 1;
    for (int k = 0; k <= 2 + cl; k++) begin
      step();
      if (k == 0) set_busy(which, busy_in_load);
      check($sformatf("%s_k%0d", tag, k), get_vec(which), exp_load(cl, k, w10, w11, w00, w01));
    end
    step();
    check({tag, "_done"}, get_vec(which), pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 1));
    step();
    check({tag, "_idle"}, get_vec(which), pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    set_busy(which, 1'b0);
  endtask

  // A capture strobe must always coincide with the pass enable.
  always @(negedge clk) begin
    if (cap0_1 || cap1_1) begin
      tests++;
      if (!pass1) begin
        fails++;
        $display("FAIL cap_without_pass_dut1: got pass=0 expected 1");
      end
    end
    if (cap0_3 || cap1_3) begin
      tests++;
      if (!pass3) begin
        fails++;
        $display("FAIL cap_without_pass_dut3: got pass=0 expected 1");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic CAP_LAT=1 load, one row per clock: inputs before the edge,
    // expected outputs just after it.
    tbl[0] = row(0, 16'h0000, 0, pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0), "basic_idle");
    tbl[1] = row(1, 16'h0403, 0, pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0), "basic_beat0");
    tbl[2] = row(1, 16'h0201, 0, pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0), "basic_beat1_armed");
    tbl[3] = row(0, 16'h0000, 0, pk(0, 8'h03, 8'h00, 1, 0, 0, 1, 0), "basic_k0");
    tbl[4] = row(0, 16'h0000, 0, pk(0, 8'h01, 8'h04, 1, 0, 0, 1, 0), "basic_k1");
    tbl[5] = row(0, 16'h0000, 0, pk(0, 8'h00, 8'h02, 1, 1, 0, 1, 0), "basic_k2");
    tbl[6] = row(0, 16'h0000, 0, pk(0, 8'h00, 8'h00, 1, 0, 1, 1, 0), "basic_k3");
    tbl[7] = row(0, 16'h0000, 0, pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 1), "basic_done");
    tbl[8] = row(0, 16'h0000, 0, pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0), "basic_back_idle");

    reset = 1'b0;
    iv1 = 0; id1 = '0; busy1 = 0;
    iv3 = 0; id3 = '0; busy3 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dut1", get_vec(1), 22'h0);
    check("reset_dut3", get_vec(3), 22'h0);
    reset = 1'b1;
    #1;
    check("post_release_not_ready", get_vec(1), 22'h0);
    step();
    check("ready_after_release_dut1", get_vec(1), pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    check("ready_after_release_dut3", get_vec(3), pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0));

    // Table-driven basic load.
    for (int i = 0; i < 9; i++) begin
      iv1 = tbl[i].iv; id1 = tbl[i].data; busy1 = tbl[i].busy;
      step();
      check(tbl[i].name, get_vec(1), tbl[i].exp);
    end
    iv1 = 0;

    // Busy stall: tile full while busy, held 5 cycles; busy raised again
    // during LOAD must not disturb the replay.
    busy1 = 1'b1;
    send_beat(1, 16'h2413, "stall_b0");
    send_beat(1, 16'h4635, "stall_b1");
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall_armed_%0d", i), get_vec(1), 22'h0);
    end
    busy1 = 1'b0;
    expect_load(1, "stall", 8'h13, 8'h24, 8'h35, 8'h46, 1'b1);

    // Backpressure: in_valid 1,0,0,1, then a third beat offered in ARMED.
    busy1 = 1'b1;
    drive(1, 1'b1, 16'h6655);
    step();
    check("bp_beat0", get_vec(1), pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    drive(1, 1'b0, 16'hDEAD);
    step();
    check("bp_gap0", get_vec(1), pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    step();
    check("bp_gap1", get_vec(1), pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    drive(1, 1'b1, 16'h8877);
    step();
    check("bp_beat1_armed", get_vec(1), 22'h0);
    drive(1, 1'b1, 16'hAA99);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_third_held_%0d", i), get_vec(1), 22'h0);
    end
    busy1 = 1'b0;
    expect_load(1, "bp", 8'h55, 8'h66, 8'h77, 8'h88, 1'b0);

    // Back-to-back: the held beat is taken only after DONE, tile B follows.
    step();
    check("b2b_beat0", get_vec(1), pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    drive(1, 1'b1, 16'hCCBB);
    step();
    check("b2b_beat1_armed", get_vec(1), 22'h0);
    drive(1, 1'b0, 16'h0000);
    expect_load(1, "b2b", 8'h99, 8'hAA, 8'hBB, 8'hCC, 1'b0);

    // Reset asserted at k=1, held for two cycles.
    send_beat(1, 16'h3121, "rst_b0");
    send_beat(1, 16'h5141, "rst_b1");
    step();
    check("rst_k0", get_vec(1), exp_load(1, 0, 8'h21, 8'h31, 8'h41, 8'h51));
    step();
    check("rst_k1", get_vec(1), exp_load(1, 1, 8'h21, 8'h31, 8'h41, 8'h51));
    reset = 1'b0;
    #1;
    check("rst_async_clear", get_vec(1), 22'h0);
    step();
    check("rst_hold_0", get_vec(1), 22'h0);
    step();
    check("rst_hold_1", get_vec(1), 22'h0);
    reset = 1'b1;
    step();
    check("rst_ready_after", get_vec(1), pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    send_beat(1, 16'hF0E0, "rst_fresh_b0");
    send_beat(1, 16'hD0C0, "rst_fresh_b1");
    expect_load(1, "rst_fresh", 8'hE0, 8'hF0, 8'hC0, 8'hD0, 1'b0);

    // CAP_LAT=3: six-step LOAD, captures at k=4 and k=5.
    send_beat(3, 16'h0403, "cl3_b0");
    send_beat(3, 16'h0201, "cl3_b1");
    check("cl3_armed", get_vec(3), 22'h0);
    expect_load(3, "cl3", 8'h03, 8'h04, 8'h01, 8'h02, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
